// File: rtl/select_adder_8.sv
// ============================================================================
//  Module      : select_adder_8
//  Description : 8-bit carry-select adder (ripple lower nibble, duplicated
//                upper nibble) with a registered {co, s} result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module select_adder_8_fa (
    input  logic x_i,
    input  logic y_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = x_i ^ y_i ^ cin_i;
    assign cout_o = (x_i & y_i) | (x_i & cin_i) | (y_i & cin_i);
endmodule

module select_adder_8_rca4 (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] w_carry;

    assign w_carry[0] = cin_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            select_adder_8_fa u_fa (
                .x_i    (x_i[gi]),
                .y_i    (y_i[gi]),
                .cin_i  (w_carry[gi]),
                .sum_o  (sum_o[gi]),
                .cout_o (w_carry[gi+1])
            );
        end
    endgenerate

    assign cout_o = w_carry[4];
endmodule

module select_adder_8 (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] s,
    output logic       co,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci
);
    logic [3:0] w_sum_lo;
    logic       w_c4;
    logic [3:0] w_sum_h0;
    logic       w_c8_0;
    logic [3:0] w_sum_h1;
    logic       w_c8_1;
    logic [4:0] w_hi_sel;
    logic [8:0] result_d;
    logic [8:0] result_q;

    select_adder_8_rca4 u_lo (
        .x_i    (a[3:0]),
        .y_i    (b[3:0]),
        .cin_i  (ci),
        .sum_o  (w_sum_lo),
        .cout_o (w_c4)
    );

    // Both upper-nibble outcomes are formed in parallel with the lower ripple.
    select_adder_8_rca4 u_hi0 (
        .x_i    (a[7:4]),
        .y_i    (b[7:4]),
        .cin_i  (1'b0),
        .sum_o  (w_sum_h0),
        .cout_o (w_c8_0)
    );

    select_adder_8_rca4 u_hi1 (
        .x_i    (a[7:4]),
        .y_i    (b[7:4]),
        .cin_i  (1'b1),
        .sum_o  (w_sum_h1),
        .cout_o (w_c8_1)
    );

    assign w_hi_sel = w_c4 ? {w_c8_1, w_sum_h1} : {w_c8_0, w_sum_h0};
    assign result_d = {w_hi_sel, w_sum_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 9'd0;
        end else begin
            result_q <= result_d;
        end
    end

    assign co = result_q[8];
    assign s  = result_q[7:0];
endmodule

`default_nettype wire

// File: tb/tb_select_adder_8.sv
// ============================================================================
//  Module      : tb_select_adder_8
//  Description : Directed and swept self-checking bench for select_adder_8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_select_adder_8;
    logic       clk;
    logic       rst_n;
    logic [7:0] s;
    logic       co;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;

    int checks;
    int errors;

    select_adder_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s),
        .co    (co),
        .a     (a),
        .b     (b),
        .ci    (ci)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {co, s};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply operands 1 ns after an edge, then check 1 ns after the capturing edge.
    task automatic add_step(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic civ, input logic [8:0] exp);
        a  = av;
        b  = bv;
        ci = civ;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [8:0] model;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        a      = 8'hFF;
        b      = 8'hFF;
        ci     = 1'b1;

        // Asynchronous reset with no clock edge yet.
        #3 rst_n = 1'b0;
        #1 check("reset_async", 9'h000);
        repeat (3) begin
            @(posedge clk);
            #1 check("reset_hold", 9'h000);
        end
        rst_n = 1'b1;

        add_step("add_5_10_1",   8'd5,   8'd10, 1'b1, 9'd16);
        add_step("add_10_33_0",  8'd10,  8'd33, 1'b0, 9'd43);
        add_step("nib_0F_01_0",  8'h0F,  8'h01, 1'b0, 9'h010);
        add_step("nib_0F_00_1",  8'h0F,  8'h00, 1'b1, 9'h010);
        add_step("nib_70_10_0",  8'h70,  8'h10, 1'b0, 9'h080);
        add_step("wrap_255_1_0", 8'd255, 8'd1,  1'b0, 9'h100);
        add_step("max_255_255_1",8'd255, 8'd255,1'b1, 9'h1FF);
        add_step("zero",         8'd0,   8'd0,  1'b0, 9'h000);

        // Back-to-back stream; each result must track its own operands only.
        add_step("pipe_1_2_0",     8'd1,   8'd2,   1'b0, 9'd3);
        add_step("pipe_100_100_0", 8'd100, 8'd100, 1'b0, 9'd200);
        add_step("pipe_128_128_1", 8'd128, 8'd128, 1'b1, 9'h101);

        // Before the next edge the output must still hold the last result.
        a = 8'd7; b = 8'd9; ci = 1'b0;
        #2 check("hold_until_edge", 9'h101);
        @(posedge clk);
        #1 check("after_edge", 9'd16);

        // Sweep every a, every 7th b, both carry-ins.
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib += 7) begin
                for (int ic = 0; ic < 2; ic++) begin
                    model = 9'(ia) + 9'(ib) + 9'(ic);
                    add_step("sweep", 8'(ia), 8'(ib), 1'(ic), model);
                end
            end
        end

        // Mid-stream reset pulse: outputs drop without a clock, then resume.
        add_step("pre_reset", 8'hC3, 8'h5A, 1'b1, 9'h11E);
        rst_n = 1'b0;
        #1 check("mid_reset_async", 9'h000);
        a = 8'h44; b = 8'h22; ci = 1'b1;
        @(posedge clk);
        #1 check("mid_reset_hold", 9'h000);
        rst_n = 1'b1;
        add_step("post_reset", 8'h44, 8'h22, 1'b1, 9'h067);
        add_step("post_reset_2", 8'hF0, 8'h20, 1'b0, 9'h110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
